gray_updown_counter: RTL and testbench
======================================

# gray_updown_counter

Parametrised N-bit Gray-code counter. It counts up or down on a qualified input strobe and supports synchronous parallel load. A Mealy terminal-count output flags the wrap or saturation event. It is the general-purpose successor of the fixed 3-bit up-only Gray counter and is used wherever multi-bit counts cross clock domains or drive low-glitch position/phase logic.

## Interface
Parameters:
- WIDTH, 3, counter width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- inp  input  1  count strobe; one step per clk edge while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled with inp.
- load  input  1  synchronous load request; takes priority over inp.
- load_val  input  WIDTH  Gray-coded value to load.
- count  output  WIDTH  registered Gray-code count.
- bin  output  WIDTH  combinational binary equivalent of count.
- out  output  1  Mealy terminal-count flag.

## Operation
- Internal state is a WIDTH-bit binary register b. count = b ^ (b >> 1), registered so that exactly one count bit toggles per step.
- Priority on each edge is load, then inp, then hold:
  - load=1: b <= gray2bin(load_val). inp and up are ignored.
  - load=0, inp=1, up=1: b <= b + 1, modulo 2^WIDTH.
  - load=0, inp=1, up=0: b <= b - 1, modulo 2^WIDTH.
  - load=0, inp=0: b holds.
- Terminal state:
  - Up direction: b = 2^WIDTH - 1, Gray 100...0.
  - Down direction: b = 0, Gray 000...0.
- out = inp & ~load & (terminal state for the current up value). It is combinational from state and inputs (Mealy), so it is high during the cycle whose edge will wrap.
- Direction may change on any cycle. No extra latency, no hold cycle.
- bin = gray2bin(count); purely combinational, valid the same cycle as count.

## Timing
- Reset: while reset_n=0, b = 0. Therefore count = 0, bin = 0, and out = 0 regardless of inp. reset_n is asserted asynchronously and is deasserted synchronously by the upstream reset synchroniser.
- Reset mid-count: the count clears immediately and out drops immediately. Counting resumes on the first edge after release if inp=1.
- Count latency: 1 clk from an inp edge sample to the new count.
- Load latency: 1 clk from load to count = load_val.
- out has zero latency relative to inp, up and the state. It must be consumed synchronously by the receiving logic.
- Simultaneous load and inp while in the terminal state: the load wins and out = 0.
- Sequence for WIDTH=3, up: 000, 001, 011, 010, 110, 111, 101, 100, 000.

## Configuration
- GRAY_COUNTER_SATURATE_EN:
  - Defined: at the terminal state with inp=1 and load=0, b holds (no wrap) and out=1 for every such cycle. A direction reversal leaves saturation normally.
  - Undefined: the counter wraps modulo 2^WIDTH, as described under Operation.
- Load and reset behaviour are identical in both builds.

## Structure
- Shared package gray_pkg holds:
  - functions bin2gray(WIDTH) and gray2bin(WIDTH), the latter as an XOR prefix from the MSB;
  - the constant MAX_WIDTH = 16.
- One sub-module, gray_to_bin, is a parametrised combinational converter. It is instantiated once for load_val and once for the bin output.
- The counter core contains the binary register, the next-state mux, the Gray output register and the out logic.

## Test plan
- Reset and up-count (WIDTH=3): reset_n low, then inp=1, up=1 for 9 clks. Required: count follows 000, 001, 011, 010, 110, 111, 101, 100, 000; out=1 only in the 100 cycle; exactly one bit changes per step.
- Down-count with wrap: from count=000, inp=1, up=0. Required: next count 100 (bin 7); out=1 in the 000 cycle.
- Load priority: at count=100 with inp=1, up=1, load=1, load_val=011. Required: out=0 and the next count is 011 (bin 2), not 000.
- Asynchronous reset mid-count: at count=110 (bin 4), assert reset_n low between edges. Required: count=000, bin=000 and out=0 before the next edge; hold until release.
- Saturation, built with GRAY_COUNTER_SATURATE_EN: count up to 100 and keep inp=1 for 3 clks. Required: count stays 100 with out=1 throughout; then up=0 gives 101. Without the macro, the same stimulus gives 000.
- Width sweep (WIDTH=2, 8, 16): count up 2^WIDTH steps for WIDTH≤8, and load 2^WIDTH-2 for 16. Required: bin equals the binary reference count, count equals bin2gray of that count, and out fires once per wrap.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers for the Gray counter family.
// Functions work on MAX_WIDTH vectors; narrower values are zero-extended by callers.
package gray_pkg;

  localparam int MAX_WIDTH = 16;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // XOR prefix from the MSB; zero upper bits leave the result unaffected.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_updown_counter_if.sv
// Control/data bundle of the Gray up/down counter: strobe, direction, load in; count, bin, flag out.
interface gray_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             inp;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] bin;
  logic             out;

  modport master (
    output inp, up, load, load_val,
    input  count, bin, out
  );

  modport slave (
    input  inp, up, load, load_val,
    output count, bin, out
  );
endinterface

// File: rtl/gray_to_bin.sv
// Parametrised combinational Gray-to-binary converter, zero latency.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic [MAX_WIDTH-1:0] full;

  assign full = gray2bin(MAX_WIDTH'(gray));
  assign bin  = full[WIDTH-1:0];

endmodule

// File: rtl/gray_updown_counter.sv
// N-bit Gray up/down counter with load priority, 1-clk latency and a Mealy terminal-count flag.
// Build option GRAY_COUNTER_SATURATE_EN: hold at the terminal state instead of wrapping.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  gray_updown_counter_if.slave bus
);

  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     b_next;
  logic [WIDTH-1:0]     load_bin;
  logic [WIDTH-1:0]     count_q;
  logic [MAX_WIDTH-1:0] gray_next;
  logic                 term;
  logic                 step;

  gray_to_bin #(.WIDTH(WIDTH)) u_load_conv (
    .gray (bus.load_val),
    .bin  (load_bin)
  );

  gray_to_bin #(.WIDTH(WIDTH)) u_bin_conv (
    .gray (count_q),
    .bin  (bus.bin)
  );

  assign term = bus.up ? (b == {WIDTH{1'b1}}) : (b == '0);
  assign step = bus.inp & ~bus.load;

  always_comb begin
    b_next = b;
    if (bus.load) begin
      b_next = load_bin;
    end else if (bus.inp) begin
`ifdef GRAY_COUNTER_SATURATE_EN
      if (!term) begin
        b_next = bus.up ? b + WIDTH'(1) : b - WIDTH'(1);
      end
`else
      b_next = bus.up ? b + WIDTH'(1) : b - WIDTH'(1);
`endif
    end
  end

  assign gray_next = bin2gray(MAX_WIDTH'(b_next));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b       <= '0;
      count_q <= '0;
    end else begin
      b       <= b_next;
      count_q <= gray_next[WIDTH-1:0];
    end
  end

  // Gated by reset so the flag stays low while held in reset, even at b=0 counting down.
  assign bus.out   = reset_n & step & term;
  assign bus.count = count_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed self-checking bench for gray_updown_counter at widths 3, 2, 8 and 16.
module tb_gray_updown_counter;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;
  int   pulses2;
  int   pulses8;
  logic [2:0] gseq [0:8];
  logic [2:0] prev;
  logic [1:0] r2;
  logic [7:0] r8;

  gray_updown_counter_if #(.WIDTH(3))  bus3 ();
  gray_updown_counter_if #(.WIDTH(2))  bus2 ();
  gray_updown_counter_if #(.WIDTH(8))  bus8 ();
  gray_updown_counter_if #(.WIDTH(16)) bus16 ();

  gray_updown_counter #(.WIDTH(3))  dut3  (.clk(clk), .reset_n(reset_n), .bus(bus3));
  gray_updown_counter #(.WIDTH(2))  dut2  (.clk(clk), .reset_n(reset_n), .bus(bus2));
  gray_updown_counter #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(bus8));
  gray_updown_counter #(.WIDTH(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0; pulses2 = 0; pulses8 = 0;
    gseq[0] = 3'b000; gseq[1] = 3'b001; gseq[2] = 3'b011; gseq[3] = 3'b010; gseq[4] = 3'b110;
    gseq[5] = 3'b111; gseq[6] = 3'b101; gseq[7] = 3'b100; gseq[8] = 3'b000;
    clk = 0; reset_n = 0;
    bus3.inp = 0;  bus3.up = 1;  bus3.load = 0;  bus3.load_val = '0;
    bus2.inp = 0;  bus2.up = 1;  bus2.load = 0;  bus2.load_val = '0;
    bus8.inp = 0;  bus8.up = 1;  bus8.load = 0;  bus8.load_val = '0;
    bus16.inp = 0; bus16.up = 1; bus16.load = 0; bus16.load_val = '0;

    // Reset state, and flag stays low in reset even when counting down from 0.
    repeat (2) tick();
    chk("rst_count", bus3.count, 3'b000);
    chk("rst_bin", bus3.bin, 3'd0);
    bus3.inp = 1; bus3.up = 0; #1;
    chk("rst_out_dn", bus3.out, 1'b0);
    bus3.up = 1; reset_n = 1; #1;

    // Up-count through the full Gray cycle.
    for (int i = 0; i < 8; i++) begin
      chk("up_count", bus3.count, gseq[i]);
      chk("up_bin", bus3.bin, i);
      chk("up_out", bus3.out, (i == 7));
      prev = bus3.count;
      tick();
      chk("up_onebit", $countones(bus3.count ^ prev), 1);
    end
    chk("up_wrap", bus3.count, gseq[8]);

    // Down-count wrap from 000.
    bus3.up = 0; #1;
    chk("dn_out", bus3.out, 1'b1);
    tick();
    chk("dn_count", bus3.count, 3'b100);
    chk("dn_bin", bus3.bin, 3'd7);
    chk("dn_out_after", bus3.out, 1'b0);

    // Load beats a wrapping count.
    bus3.up = 1; #1;
    chk("ld_term_out", bus3.out, 1'b1);
    bus3.load = 1; bus3.load_val = 3'b011; #1;
    chk("ld_out", bus3.out, 1'b0);
    tick();
    bus3.load = 0;
    chk("ld_count", bus3.count, 3'b011);
    chk("ld_bin", bus3.bin, 3'd2);

    // Asynchronous reset between edges.
    tick();
    tick();
    chk("pre_rst_count", bus3.count, 3'b110);
    chk("pre_rst_bin", bus3.bin, 3'd4);
    #2; reset_n = 0; bus3.up = 0; #1;
    chk("arst_count", bus3.count, 3'b000);
    chk("arst_bin", bus3.bin, 3'd0);
    chk("arst_out", bus3.out, 1'b0);
    repeat (2) tick();
    chk("arst_hold", bus3.count, 3'b000);
    reset_n = 1; bus3.up = 1; #1;
    chk("rel_out", bus3.out, 1'b0);
    tick();
    chk("rel_count", bus3.count, 3'b001);

    // Terminal state held with the strobe high.
    repeat (6) tick();
    chk("term_count", bus3.count, 3'b100);
    chk("term_out", bus3.out, 1'b1);
    tick();
`ifdef GRAY_COUNTER_SATURATE_EN
    chk("sat_count1", bus3.count, 3'b100);
    chk("sat_out1", bus3.out, 1'b1);
    tick();
    tick();
    chk("sat_count3", bus3.count, 3'b100);
    chk("sat_out3", bus3.out, 1'b1);
    bus3.up = 0; #1;
    tick();
    chk("sat_rev", bus3.count, 3'b101);
`else
    chk("wrap_count1", bus3.count, 3'b000);
    chk("wrap_out1", bus3.out, 1'b0);
    tick();
    tick();
    chk("wrap_count3", bus3.count, 3'b011);
    bus3.up = 0; #1;
    tick();
    chk("wrap_rev", bus3.count, 3'b001);
`endif
    bus3.inp = 0;

    // Width sweep: 2 and 8 count a full cycle against a reference.
    bus2.inp = 1; bus8.inp = 1; #1;
    for (int i = 0; i < 256; i++) begin
      r2 = 2'(i);
      r8 = 8'(i);
      chk("w2_bin", bus2.bin, r2);
      chk("w2_gray", bus2.count, r2 ^ (r2 >> 1));
      chk("w2_out", bus2.out, (r2 == 2'd3));
      chk("w8_bin", bus8.bin, r8);
      chk("w8_gray", bus8.count, r8 ^ (r8 >> 1));
      chk("w8_out", bus8.out, (r8 == 8'd255));
      if (bus2.out) pulses2++;
      if (bus8.out) pulses8++;
      tick();
    end
    bus2.inp = 0; bus8.inp = 0;
    chk("w2_pulses", pulses2, 64);
    chk("w8_pulses", pulses8, 1);
    chk("w2_end", bus2.count, 2'b00);
    chk("w8_end", bus8.count, 8'h00);

    // Width 16: load 0xFFFE (Gray 0x8001) then step across the wrap.
    bus16.load = 1; bus16.load_val = 16'h8001;
    tick();
    bus16.load = 0;
    chk("w16_ld_bin", bus16.bin, 16'hFFFE);
    chk("w16_ld_count", bus16.count, 16'h8001);
    bus16.inp = 1; bus16.up = 1; #1;
    chk("w16_out0", bus16.out, 1'b0);
    tick();
    chk("w16_count_max", bus16.count, 16'h8000);
    chk("w16_bin_max", bus16.bin, 16'hFFFF);
    chk("w16_out_max", bus16.out, 1'b1);
    tick();
    chk("w16_wrap", bus16.count, 16'h0000);
    chk("w16_out_wrap", bus16.out, 1'b0);
    bus16.inp = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
